// File: rtl/code_lock_ctrl.sv
// Two-key combination lock sequencer: digit entry, code check, lockout,
// entry timeout and in-field re-programming of the stored code.
module code_lock_ctrl #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = CODE_LEN'(4'b1001),
    parameter int                  MAX_FAIL       = 3,
    parameter int                  UNLOCK_CYCLES  = 1000,
    parameter int                  LOCKOUT_CYCLES = 5000,
    parameter int                  ENTRY_TIMEOUT  = 20000,
    parameter int                  TMR_W          = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key0_p,
    input  logic                key1_p,
    output logic                unlock,
    output logic                alarm,
    output logic                prog_mode,
    output logic [3:0]          digit_cnt,
    output logic [CODE_LEN-1:0] entry_bits,
    output logic [1:0]          fail_cnt,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4,
        S_PROGRAM = 3'd5
    } state_t;

    localparam logic [TMR_W-1:0] ENTRY_LAST  = TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LAST = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCKOUT_CYCLES - 1);

    state_t              r_state;
    logic [CODE_LEN-1:0] r_code;
    logic [CODE_LEN-1:0] r_entry;
    logic [3:0]          r_cnt;
    logic [1:0]          r_fail;
    logic [TMR_W-1:0]    r_tmr;

    logic                w_digit;
    logic                w_chord;
    logic [CODE_LEN-1:0] w_next_bits;
    logic [3:0]          w_next_cnt;
    logic                w_full;
    logic [TMR_W-1:0]    w_tmr_inc;
    logic                w_lock_now;

    assign w_digit     = key0_p ^ key1_p;
    assign w_chord     = key0_p & key1_p;
    assign w_next_bits = {r_entry[CODE_LEN-2:0], key1_p};
    assign w_next_cnt  = r_cnt + 4'd1;
    assign w_full      = (w_next_cnt == 4'(CODE_LEN));
    assign w_tmr_inc   = (r_tmr == '1) ? r_tmr : r_tmr + 1'b1;
    assign w_lock_now  = ((r_fail + 2'd1) == 2'(MAX_FAIL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_code  <= DEFAULT_CODE;
            r_entry <= '0;
            r_cnt   <= '0;
            r_fail  <= '0;
            r_tmr   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_digit) begin
                        r_entry <= w_next_bits;
                        r_cnt   <= w_next_cnt;
                        r_tmr   <= '0;
                        r_state <= w_full ? S_CHECK : S_ENTRY;
                    end
                end
                S_ENTRY, S_PROGRAM: begin
                    // A digit on the timeout edge wins over the timeout
                    if (w_digit) begin
                        r_tmr <= '0;
                        if (w_full && r_state == S_PROGRAM) begin
                            r_code  <= w_next_bits;
                            r_entry <= '0;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_entry <= w_next_bits;
                            r_cnt   <= w_next_cnt;
                            if (w_full) r_state <= S_CHECK;
                        end
                    end else if (r_tmr == ENTRY_LAST) begin
                        r_entry <= '0;
                        r_cnt   <= '0;
                        r_tmr   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= w_tmr_inc;
                    end
                end
                S_CHECK: begin
                    r_entry <= '0;
                    r_cnt   <= '0;
                    r_tmr   <= '0;
                    if (r_entry == r_code) begin
                        r_fail  <= '0;
                        r_state <= S_OPEN;
                    end else if (w_lock_now) begin
                        r_fail  <= 2'(MAX_FAIL);
                        r_state <= S_LOCKOUT;
                    end else begin
                        r_fail  <= r_fail + 2'd1;
                        r_state <= S_IDLE;
                    end
                end
                S_OPEN: begin
                    if (r_tmr == UNLOCK_LAST) begin
                        r_tmr   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_chord) begin
                        r_tmr   <= '0;
                        r_entry <= '0;
                        r_cnt   <= '0;
                        r_state <= S_PROGRAM;
                    end else begin
                        r_tmr <= w_tmr_inc;
                    end
                end
                S_LOCKOUT: begin
                    if (r_tmr == LOCK_LAST) begin
                        r_tmr   <= '0;
                        r_fail  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= w_tmr_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign unlock     = (r_state == S_OPEN);
    assign alarm      = (r_state == S_LOCKOUT);
    assign prog_mode  = (r_state == S_PROGRAM);
    assign digit_cnt  = r_cnt;
    assign entry_bits = r_entry;
    assign fail_cnt   = r_fail;
    assign state      = r_state;

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Sequencing controller for the two-key combination lock.
- Consumes debounced single-cycle key pulses (key0 = bit 0, key1 = bit 1) and assembles them into a CODE_LEN-bit entry, which it compares against a stored code.
- Drives unlock, alarm and the digit and status values that feed the 8-digit display scan.
- Supports failed-attempt lockout, entry timeout, and re-programming of the code while open.

Parameters:
CODE_LEN, 4, digits per code (2..15)
DEFAULT_CODE, 4'b1001, code loaded on reset, MSB = first digit entered
MAX_FAIL, 3, consecutive wrong codes that trigger lockout (1..3)
UNLOCK_CYCLES, 1000, cycles unlock stays high
LOCKOUT_CYCLES, 5000, cycles alarm stays high
ENTRY_TIMEOUT, 20000, idle cycles allowed between digits in ENTRY/PROGRAM
TMR_W, 24, timer width; must hold the largest cycle parameter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
key0_p  in  1  debounced one-cycle pulse, digit 0
key1_p  in  1  debounced one-cycle pulse, digit 1
unlock  out  1  high while in OPEN
alarm  out  1  high while in LOCKOUT
prog_mode  out  1  high while in PROGRAM
digit_cnt  out  4  digits collected in the current entry
entry_bits  out  CODE_LEN  digits collected so far, right-aligned
fail_cnt  out  2  consecutive failed attempts
state  out  3  IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4, PROGRAM=5

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE; code register=DEFAULT_CODE; all outputs 0; timer=0.
  - A code change from PROGRAM that has not yet committed is lost.
- Key event:
  - A key event is exactly one of key0_p or key1_p sampled high.
  - Both high in the same cycle is a "chord", not a digit.
  - A chord is ignored in every state except OPEN.
- Digit capture:
  - entry_bits <= {entry_bits[CODE_LEN-2:0], bit}.
  - digit_cnt increments on the same edge.
  - timer clears on every accepted digit.
- IDLE:
  - First digit: capture it, go to ENTRY (digit_cnt=1).
  - If CODE_LEN is reached on that edge, go straight to CHECK.
- ENTRY:
  - Each digit is captured.
  - The edge that makes digit_cnt==CODE_LEN moves to CHECK.
  - timer reaching ENTRY_TIMEOUT with no digit: go to IDLE, clear entry_bits/digit_cnt; fail_cnt is unchanged (a timeout is not an attempt).
- CHECK (exactly 1 cycle; keys ignored):
  - entry_bits==code: go to OPEN, fail_cnt=0.
  - Else if fail_cnt+1==MAX_FAIL: go to LOCKOUT, fail_cnt=MAX_FAIL.
  - Else: go to IDLE, fail_cnt+1.
  - entry_bits/digit_cnt clear on leaving CHECK.
- Latency:
  - Last digit sampled at edge k gives CHECK after edge k and unlock=1 after edge k+1.
  - unlock/alarm/prog_mode are decoded from the state register; no combinational path from the keys.
- OPEN:
  - unlock=1 for exactly UNLOCK_CYCLES cycles, then IDLE.
  - Single keys are ignored.
  - Chord: go to PROGRAM, timer=0, entry cleared.
- PROGRAM:
  - Digits are captured as in ENTRY.
  - On the CODE_LEN-th digit, the code register <= new entry (including that digit) and the state goes to IDLE.
  - Timeout: go to IDLE, code unchanged.
- LOCKOUT:
  - alarm=1 for exactly LOCKOUT_CYCLES cycles; all keys ignored.
  - Then go to IDLE with fail_cnt=0.
- Simultaneous events:
  - A digit arriving on the same edge the timeout would fire wins: it is captured and the timer is cleared.
  - A key arriving on the edge OPEN/LOCKOUT expires is ignored.
- Timer saturates at 2^TMR_W-1 and never wraps.

Test Plan:
- Tests use UNLOCK_CYCLES=20, LOCKOUT_CYCLES=50, ENTRY_TIMEOUT=100.
- Reset, then pulses key1,key0,key0,key1 → state 1,1,1,2,3; unlock=1 two cycles after the 4th pulse, held exactly 20 cycles; fail_cnt=0; entry_bits shows 1,10,100,then clears.
- Wrong code 1111 entered three times → fail_cnt 1,2, then state=4; alarm high 50 cycles; key pulses during the alarm have no effect; then state=0, fail_cnt=0.
- key1 only, then 100 idle cycles → state returns to 0, digit_cnt=0, fail_cnt unchanged.
- Correct code, then a chord in OPEN → prog_mode=1; enter 0110 → state=0. Old code 1001 now fails; 0110 unlocks.
- Chord in IDLE/ENTRY → no state or entry change.
- Assert rst mid-ENTRY (2 digits) and mid-PROGRAM → all outputs 0 immediately; code = 1001.
